rr_onehot_arbiter: RTL
======================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter for a shared resource selected by a 4-to-16 one-hot select.
- Sits in front of the one-hot decode datapath and shares it between 16 requesters.
- Grants exactly one requester at a time and holds the grant until release.
- Drives both the 4-bit index and the matching 16-bit one-hot grant, so downstream logic can use either form.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 in this revision, index width 4.
- MAX_HOLD, 255, maximum grant-hold cycles before forced release; used only with ARB_TIMEOUT_EN; 8-bit counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  16  request vector; bit i = requester i wants the resource.
- done  input  1  one-cycle pulse from the granted requester: transaction finished.
- grant  output  16  one-hot grant; bit i set = requester i owns the resource.
- grant_idx  output  4  binary index of the current owner; valid only when grant_valid=1.
- grant_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- All outputs are registered.
- Reset values: grant=16'h0000, grant_idx=4'd0, grant_valid=0, timeout=0. Internal: priority pointer ptr=4'd0, state=IDLE, hold counter=0.
- rst sampled high on any edge, including mid-grant, forces the reset values on the next cycle. The grant drops immediately, with no RELEASE gap.
- States: IDLE, OWN, RELEASE.
- IDLE:
  - If req != 0, select the winner: first set bit scanning ptr, ptr+1, ..., ptr+15, with indices mod 16.
  - Next cycle: state=OWN, grant_idx=winner, grant = 16'h0001 << winner, grant_valid=1.
  - Grant latency is exactly 1 cycle from the first cycle req is seen.
  - If req == 0, stay in IDLE with all outputs 0.
- OWN:
  - Release condition: done=1, OR req[grant_idx]=0 (requester withdrew), OR (with macro) hold counter reaches MAX_HOLD.
  - On release: next state RELEASE, ptr <= grant_idx + 1 (4-bit wrap, so 15 -> 0).
  - Otherwise hold grant and grant_idx unchanged. Changes to other req bits are ignored while in OWN.
- RELEASE:
  - One cycle with grant=0 and grant_valid=0 (guard gap so the shared resource never sees two owners back-to-back).
  - Then go to IDLE. Arbitration happens in IDLE, so the minimum grant-to-next-grant spacing is OWN(>=1) + RELEASE(1) + IDLE(1).
- Invariants:
  - grant is always either zero or one-hot.
  - grant == (grant_valid ? 1<<grant_idx : 0).
- done while in IDLE or RELEASE is ignored.
- done and req withdrawal in the same cycle count as a single release; ptr advances once.
- Fairness: a continuously requesting requester is granted within 15 other grants.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to OWN and increments each OWN cycle.
  - When it equals MAX_HOLD while still in OWN with no other release condition, force release as normal and pulse timeout=1 for one cycle, aligned with the RELEASE state.
  - If done arrives in the same cycle the counter hits MAX_HOLD, this is a normal release with no timeout pulse.
- When not defined: no counter; timeout is tied to 0; a grant is held indefinitely until done or withdrawal.

Test Plan:
1. Reset then single request: rst high 2 cycles, then req=16'h0010 -> next cycle grant=16'h0010, grant_idx=4, grant_valid=1. Pulse done -> one RELEASE cycle with grant=0, then ptr=5.
2. Round-robin rotation: req=16'h8001 held constant, done pulsed each OWN -> grants alternate idx 0, 15, 0, 15. After idx 15 releases, ptr wraps to 0.
3. Pointer priority: after the idx 4 release (ptr=5), req=16'h0028 (bits 3 and 5) -> grant idx 5. Then after release -> idx 3.
4. Withdrawal: granted idx 7, drop req[7] with no done -> release next cycle, ptr=8, timeout=0.
5. Reset mid-grant: grant idx 9 held, assert rst for 1 cycle -> next cycle grant=0, grant_valid=0, grant_idx=0, ptr=0. With req=16'h0200 still high after reset, idx 9 is re-granted 1 cycle later.
6. Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): grant idx 2, req held, no done -> after 4 OWN cycles timeout pulses 1 cycle with grant=0. Repeat with done on the 4th cycle -> no timeout pulse. Without the macro, the same stimulus holds the grant for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter sharing a 4-to-16 one-hot select between 16 requesters.
// Latency: grant registered 1 cycle after req is seen in IDLE; one idle guard cycle after each release.
// Backpressure: grant held until done or withdrawal (or forced release with ARB_TIMEOUT_EN defined).
module rr_onehot_arbiter #(
  parameter int N_REQ    = 16,
  parameter int MAX_HOLD = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [3:0]       grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  // The index width and the 8-bit hold counter are fixed in this revision.
  if (N_REQ != 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_onehot_arbiter: N_REQ must be 16 and MAX_HOLD must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  ptr, ptr_d;
  logic [3:0]  idx_d;
  logic        valid_d;
  logic        timeout_d;
  logic [15:0] grant_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;

  logic        owner_release;
  logic        hold_hit;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  logic [7:0] hold_cnt, hold_cnt_d, hold_inc;

  // Forced release fires on the OWN cycle that would bring the count to MAX_HOLD,
  // so exactly MAX_HOLD OWN cycles are granted before the timeout.
  assign hold_inc = hold_cnt + 8'd1;
  assign hold_hit = (hold_inc == HOLD_LIM);
`else
  assign hold_hit = 1'b0;
`endif

  // Requester withdrawal and done are the same release event; both together release once.
  assign owner_release = done || !req[grant_idx];

  // Winner search: first set request bit scanning ptr, ptr+1, ... with 4-bit wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are zero except while owning.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    idx_d     = 4'd0;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_d = OWN;
          idx_d   = win_idx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      OWN: begin
        if (owner_release || hold_hit) begin
          state_d   = RELEASE;
          ptr_d     = grant_idx + 4'd1;
          timeout_d = !owner_release;
        end else begin
          idx_d   = grant_idx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_inc;
`endif
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant_d = valid_d ? (16'h0001 << idx_d) : 16'h0000;

  // State, pointer and registered outputs; reset wins over any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      grant       <= 16'h0000;
      grant_idx   <= 4'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      grant       <= grant_d;
      grant_idx   <= idx_d;
      grant_valid <= valid_d;
      timeout     <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: cleared when a grant is issued, counts OWN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt_d;
    end
  end
`endif

endmodule
